// File: rtl/noc_pkg.sv
// Shared mesh NoC definitions: packet layout, field positions and record types
// used by the packet generators and the packet sink.
package noc_pkg;

    localparam int ADDR_W    = 4;
    localparam int TS_W      = 32;
    localparam int PKT_W     = TS_W + 2 * ADDR_W;   // 40
    localparam int DEST_LSB  = 0;
    localparam int SRC_LSB   = DEST_LSB + ADDR_W;   // 4
    localparam int TS_LSB    = SRC_LSB + ADDR_W;    // 8
    localparam int REC_W     = ADDR_W + TS_W;       // 36
    localparam int LAT_SUM_W = 48;

    // Packet as it travels the mesh: [39:8] ts, [7:4] src, [3:0] dest
    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dest;
    } pkt_t;

    // Delivered-packet record held in the sink FIFO
    typedef struct packed {
        logic [ADDR_W-1:0] src;
        logic [TS_W-1:0]   latency;
    } rec_t;

    // Latency is a plain modular difference so a counter wrap between
    // injection and delivery still yields the small true value.
    function automatic logic [TS_W-1:0] calc_latency(input logic [TS_W-1:0] now,
                                                     input logic [TS_W-1:0] ts);
        return now - ts;
    endfunction

endpackage

// File: rtl/packet_sink_if.sv
// Inbound packet channel plus outbound delivered-record channel of the sink.
interface packet_sink_if;
    import noc_pkg::*;

    logic              in_valid;
    pkt_t              in_packet;
    logic              in_ready;
    logic              out_valid;
    logic [ADDR_W-1:0] out_src;
    logic [TS_W-1:0]   out_latency;
    logic              out_ready;

    // Packet source and record consumer side
    modport master (
        output in_valid, in_packet, out_ready,
        input  in_ready, out_valid, out_src, out_latency
    );

    // Sink side
    modport slave (
        input  in_valid, in_packet, out_ready,
        output in_ready, out_valid, out_src, out_latency
    );

endinterface

// File: rtl/sync_fifo.sv
// Register-based synchronous FIFO. Head data is read straight from the array,
// so a pushed word reaches the head on the cycle after the push. No bypass:
// full is purely a function of stored occupancy.
module sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    // Empty FIFO presents zeros rather than a stale record
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^AW)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because empty masks the output
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/packet_sink.sv
// Mesh packet sink: accepts packets addressed to this node, records source and
// latency into a FIFO, keeps delivery/misroute counts and latency statistics.
module packet_sink
    import noc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TS_W-1:0]      ctr,
    input  logic [ADDR_W-1:0]    node_addr,
    packet_sink_if.slave         bus,
    output logic [CNT_W-1:0]     pkt_count,
    output logic [CNT_W-1:0]     misroute_count,
    output logic [LAT_SUM_W-1:0] lat_sum,
    output logic [TS_W-1:0]      lat_min,
    output logic [TS_W-1:0]      lat_max
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pkt_t               pkt;
    rec_t               rec_in;
    rec_t               rec_out;
    logic               full;
    logic               empty;
    logic               accept;
    logic               deliver;
    logic               misroute;
    logic               pop;
    logic [TS_W-1:0]    latency;
    logic [LAT_SUM_W:0] sum_ext;

    assign pkt      = bus.in_packet;
    assign accept   = bus.in_valid & ~full;
    assign deliver  = accept & (pkt.dest == node_addr);
    assign misroute = accept & (pkt.dest != node_addr);
    assign latency  = calc_latency(ctr, pkt.ts);
    assign rec_in   = '{src: pkt.src, latency: latency};
    assign pop      = ~empty & bus.out_ready;
    // One extra bit catches the carry that signals lat_sum saturation
    assign sum_ext  = {1'b0, lat_sum} + {{(LAT_SUM_W + 1 - TS_W){1'b0}}, latency};

    assign bus.in_ready    = ~full;
    assign bus.out_valid   = ~empty;
    assign bus.out_src     = rec_out.src;
    assign bus.out_latency = rec_out.latency;

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (deliver),
        .din   (rec_in),
        .pop   (pop),
        .dout  (rec_out),
        .full  (full),
        .empty (empty)
    );

    // Delivery/misroute counters and latency statistics, all saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count      <= '0;
            misroute_count <= '0;
            lat_sum        <= '0;
            lat_min        <= '1;
            lat_max        <= '0;
        end else begin
            if (deliver) begin
                if (pkt_count != CNT_MAX) pkt_count <= pkt_count + 1'b1;
                lat_sum <= sum_ext[LAT_SUM_W] ? '1 : sum_ext[LAT_SUM_W-1:0];
                if (latency < lat_min) lat_min <= latency;
                if (latency > lat_max) lat_max <= latency;
            end
            if (misroute && misroute_count != CNT_MAX)
                misroute_count <= misroute_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_packet_sink.sv
// Bench for packet_sink: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a queue-based model.
module tb_packet_sink;
    import noc_pkg::*;

    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 16;
    localparam logic [63:0] SUM_MAX = 64'h0000_FFFF_FFFF_FFFF;

    logic                 clk;
    logic                 rst;
    logic [31:0]          ctr;
    logic [3:0]           node_addr;
    logic [CNT_W-1:0]     pkt_count;
    logic [CNT_W-1:0]     misroute_count;
    logic [47:0]          lat_sum;
    logic [31:0]          lat_min;
    logic [31:0]          lat_max;

    packet_sink_if bus ();

    packet_sink #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .ctr            (ctr),
        .node_addr      (node_addr),
        .bus            (bus),
        .pkt_count      (pkt_count),
        .misroute_count (misroute_count),
        .lat_sum        (lat_sum),
        .lat_min        (lat_min),
        .lat_max        (lat_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [3:0]  src;
        logic [31:0] lat;
    } mrec_t;

    mrec_t            m_q[$];
    mrec_t            m_r;
    bit               m_valid = 1'b0;
    int               m_n;
    logic [CNT_W-1:0] m_pkt, m_mis;
    logic [63:0]      m_sum;
    logic [31:0]      m_min, m_max, m_lat;
    logic [39:0]      m_p;

    // Compare DUT against the model, then advance the model across the next edge.
    // Inputs only change just after a rising edge, so they are stable here.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("in_ready", bus.in_ready, m_q.size() < FIFO_DEPTH);
            chk("out_valid", bus.out_valid, m_q.size() != 0);
            if (m_q.size() != 0) begin
                chk("out_src", bus.out_src, m_q[0].src);
                chk("out_latency", bus.out_latency, m_q[0].lat);
            end
            chk("pkt_count", pkt_count, m_pkt);
            chk("misroute_count", misroute_count, m_mis);
            chk("lat_sum", lat_sum, m_sum);
            chk("lat_min", lat_min, m_min);
            chk("lat_max", lat_max, m_max);
        end
        if (rst) begin
            m_q.delete();
            m_pkt = '0; m_mis = '0; m_sum = '0; m_min = '1; m_max = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_n = m_q.size();
            m_p = bus.in_packet;
            if (bus.out_ready && m_n > 0) void'(m_q.pop_front());
            if (bus.in_valid && m_n < FIFO_DEPTH) begin
                if (m_p[3:0] == node_addr) begin
                    m_lat = ctr - m_p[39:8];
                    m_r.src = m_p[7:4];
                    m_r.lat = m_lat;
                    m_q.push_back(m_r);
                    if (m_pkt != '1) m_pkt = m_pkt + 1'b1;
                    m_sum = (m_sum + m_lat > SUM_MAX) ? SUM_MAX : m_sum + m_lat;
                    if (m_lat < m_min) m_min = m_lat;
                    if (m_lat > m_max) m_max = m_lat;
                end else if (m_mis != '1) begin
                    m_mis = m_mis + 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input logic [3:0] dest, input logic [3:0] src, input logic [31:0] ts);
        bus.in_packet = {ts, src, dest};
    endtask

    task automatic send(input logic [3:0] dest, input logic [3:0] src, input logic [31:0] ts);
        bus.in_valid = 1'b1;
        set_pkt(dest, src, ts);
        tick;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ctr = 32'd0;
        node_addr = 4'd5;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_packet = '0;
        tick;
        tick;
        // reset state
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst in_ready", bus.in_ready, 1);
        chk("rst out_src", bus.out_src, 0);
        chk("rst out_latency", bus.out_latency, 0);
        chk("rst lat_min", lat_min, 32'hFFFF_FFFF);
        chk("rst pkt_count", pkt_count, 0);
        rst = 1'b0;

        // single delivery
        ctr = 32'd100;
        send(4'd5, 4'd2, 32'd90);
        chk("single pkt_count", pkt_count, 1);
        chk("single lat_min", lat_min, 10);
        chk("single lat_max", lat_max, 10);
        chk("single lat_sum", lat_sum, 10);
        chk("single out_valid", bus.out_valid, 1);
        chk("single out_src", bus.out_src, 2);
        chk("single out_latency", bus.out_latency, 10);

        // misroute
        do_reset;
        send(4'd3, 4'd1, 32'd50);
        chk("misroute count", misroute_count, 1);
        chk("misroute pkt_count", pkt_count, 0);
        chk("misroute out_valid", bus.out_valid, 0);

        // timestamp wrap
        do_reset;
        ctr = 32'd3;
        send(4'd5, 4'd7, 32'hFFFF_FFFE);
        chk("wrap out_latency", bus.out_latency, 5);
        chk("wrap out_src", bus.out_src, 7);

        // backpressure with out_ready low
        do_reset;
        ctr = 32'd1000;
        for (int i = 1; i <= 4; i++) send(4'd5, 4'(i), 32'd1000 - 32'(10 * i));
        chk("bp in_ready full", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        set_pkt(4'd5, 4'd5, 32'd950);
        tick;
        tick;
        chk("bp held in_ready", bus.in_ready, 0);
        chk("bp held pkt_count", pkt_count, 4);
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        chk("bp after pop in_ready", bus.in_ready, 1);
        chk("bp after pop pkt_count", pkt_count, 4);
        chk("bp after pop head", bus.out_src, 2);
        tick;
        bus.in_valid = 1'b0;
        chk("bp 5th accepted", pkt_count, 5);
        chk("bp full again", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk("bp order", bus.out_src, 4'(i));
            tick;
        end
        bus.out_ready = 1'b0;
        chk("bp drained", bus.out_valid, 0);

        // simultaneous push and pop with two entries
        do_reset;
        send(4'd5, 4'd1, 32'd990);
        send(4'd5, 4'd2, 32'd980);
        bus.in_valid = 1'b1;
        set_pkt(4'd5, 4'd3, 32'd970);
        bus.out_ready = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        chk("pp head advanced", bus.out_src, 2);
        chk("pp pkt_count", pkt_count, 3);
        tick;
        chk("pp second entry valid", bus.out_valid, 1);
        chk("pp second entry", bus.out_src, 3);
        tick;
        bus.out_ready = 1'b0;
        chk("pp occupancy was 2", bus.out_valid, 0);

        // reset mid-run with three entries queued and a transfer in the reset cycle
        for (int i = 1; i <= 3; i++) send(4'd5, 4'(i), 32'd900);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        set_pkt(4'd5, 4'd9, 32'd900);
        tick;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("mid rst out_valid", bus.out_valid, 0);
        chk("mid rst pkt_count", pkt_count, 0);
        chk("mid rst misroute", misroute_count, 0);
        chk("mid rst lat_sum", lat_sum, 0);
        chk("mid rst lat_max", lat_max, 0);
        chk("mid rst lat_min", lat_min, 32'hFFFF_FFFF);
        chk("mid rst in_ready", bus.in_ready, 1);
        tick;
        chk("mid rst stays empty", bus.out_valid, 0);

        // randomized traffic across a counter wrap, checked by the model
        ctr = 32'hFFFF_FF80;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            rst = ($urandom_range(0, 249) == 0);
            bus.in_valid = ($urandom_range(0, 2) != 0);
            set_pkt(($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : node_addr,
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 15) == 0) ? $urandom : ctr - 32'($urandom_range(0, 500)));
            if (cyc < 1000) bus.out_ready = ($urandom_range(0, 2) == 0);
            else            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick;
            ctr = ctr + 32'd1;
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_sink.md
PACKET_SINK -- requirements
Module: packet_sink

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sets the number of received-packet entries; power of two, 2..16.
REQ-002 Parameter CNT_W, default 16, sets the width of the packet and misroute counters.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ctr  input  32  global cycle counter, the same value the packet generators stamp.
REQ-006 node_addr  input  4  this node's mesh address.
REQ-007 in_valid  input  1  an inbound packet is present on in_packet.
REQ-008 in_packet  input  40  packet: [3:0] dest, [7:4] src, [39:8] injection timestamp.
REQ-009 in_ready  output  1  the sink can accept a packet this cycle.
REQ-010 out_valid  output  1  the FIFO head holds a delivered-packet record.
REQ-011 out_src  output  4  source address of the head record.
REQ-012 out_latency  output  32  latency of the head record.
REQ-013 out_ready  input  1  the consumer pops the head record.
REQ-014 pkt_count  output  CNT_W  number of packets accepted for this node.
REQ-015 misroute_count  output  CNT_W  number of accepted packets whose dest did not equal node_addr.
REQ-016 lat_sum  output  48  sum of the latencies of all delivered packets.
REQ-017 lat_min, lat_max  output  32 each  minimum and maximum delivered latency.

Function
REQ-018 A transfer shall occur on a cycle with in_valid=1 and in_ready=1; nothing is sampled otherwise.
REQ-019 in_ready shall be 1 exactly when the FIFO is not full; there is no bypass, so a pop in the same cycle does not raise in_ready.
REQ-020 On transfer with in_packet[3:0]==node_addr, the sink shall push {src, latency} with latency = ctr - in_packet[39:8], computed modulo 2^32 so that counter wrap yields the correct small value.
REQ-021 On transfer with dest!=node_addr, the packet shall be dropped, misroute_count incremented, and the FIFO and latency statistics left unchanged.
REQ-022 On a delivered transfer, pkt_count, lat_sum, lat_min and lat_max shall update, visible on the cycle after the transfer.
REQ-023 pkt_count and misroute_count shall saturate at all-ones; lat_sum shall saturate at 2^48-1.
REQ-024 A pushed record shall appear at the FIFO head no earlier than the next cycle; the FIFO read latency is one cycle.
REQ-025 The FIFO shall pop when out_valid and out_ready are both 1; out_ready while empty has no effect.
REQ-026 A simultaneous push and pop with the FIFO neither empty nor full shall leave the occupancy unchanged and preserve order.
REQ-027 While out_valid=1 and out_ready=0, out_src and out_latency shall hold stable.
REQ-028 The FIFO pointers shall wrap modulo FIFO_DEPTH; occupancy shall be tracked in a log2(FIFO_DEPTH)+1 bit count.

Reset
REQ-029 On rst=1 at a clock edge, the FIFO shall be flushed, and all counters and lat_sum and lat_max set to 0.
REQ-030 On the same reset, lat_min shall be set to 32'hFFFF_FFFF, out_valid to 0, in_ready to 1, and out_src and out_latency to 0.
REQ-031 Reset asserted mid-operation shall discard in-flight records, and a transfer presented in the reset cycle shall be ignored.

Structure
REQ-032 A shared package noc_pkg shall hold PKT_W=40, ADDR_W=4, TS_W=32, the field bit positions, and a packed struct type for the packet; this block and the generator node shall both use it.
REQ-033 The FIFO shall be a separate sub-module, sync_fifo (parameters WIDTH and DEPTH), instantiated once with WIDTH=36.

Verification
REQ-034 The bench shall cover the single-delivery case: node_addr=5, ctr=100, packet dest=5, src=2, ts=90 -> next cycle pkt_count=1, lat_min=lat_max=lat_sum=10, out_valid=1, out_src=2, out_latency=10.
REQ-035 The bench shall cover misrouting: node_addr=5, a packet with dest=3 -> misroute_count=1, pkt_count=0, out_valid stays 0.
REQ-036 The bench shall cover timestamp wrap: ctr=3, ts=32'hFFFF_FFFE -> out_latency=5.
REQ-037 The bench shall cover backpressure: out_ready=0 and 5 deliveries with FIFO_DEPTH=4 -> in_ready=0 after the 4th, the 5th is held by the source, and it is accepted one cycle after the first pop; order is preserved.
REQ-038 The bench shall cover a combined push/pop: with 2 entries, a push and a pop in the same cycle -> occupancy stays 2 and the head advances.
REQ-039 The bench shall cover reset mid-run: rst with 3 entries queued -> next cycle out_valid=0, all counters 0, lat_min=32'hFFFF_FFFF.
